// File: rtl/feistel_cipher_core.sv
// Iterative Feistel block cipher: one round per clock, runtime encrypt/decrypt,
// valid/ready handshakes on both sides, and an abort that discards the block.
module feistel_cipher_core #(
  parameter int unsigned BLOCK_W = 64,
  parameter int unsigned ROUNDS  = 16,
  parameter int unsigned KEY_ROT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               enc_dec,
  input  logic [BLOCK_W-1:0] key,
  input  logic [BLOCK_W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic               busy,
  input  logic               abort
);

  localparam int unsigned HALF  = BLOCK_W / 2;
  localparam int unsigned CNT_W = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [HALF-1:0]    l;
  logic [HALF-1:0]    r;
  logic [BLOCK_W-1:0] key_q;
  logic               enc_q;

  logic [CNT_W-1:0]   idx;
  int unsigned        amt;
  logic [HALF-1:0]    rk;
  logic [HALF-1:0]    mix;
  logic [HALF-1:0]    f;
  logic [HALF-1:0]    l_nxt;
  logic [HALF-1:0]    r_nxt;
  logic               last;

  // Round datapath: subkey selection (reversed order for decrypt) and one Feistel round
  always_comb begin
    idx   = enc_q ? cnt : CNT_W'(ROUNDS - 1) - cnt;
    amt   = (32'(idx) * KEY_ROT) % BLOCK_W;
    // a zero rotate makes the right shift span the full width and contribute nothing
    rk    = HALF'(key_q << amt) | HALF'(key_q >> (BLOCK_W - amt));
    mix   = r ^ rk;
    f     = {mix[HALF-4:0], mix[HALF-1:HALF-3]} + (r & rk);
    l_nxt = r;
    r_nxt = l ^ f;
    last  = (cnt == CNT_W'(ROUNDS - 1));
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      cnt       <= '0;
      l         <= '0;
      r         <= '0;
      key_q     <= '0;
      enc_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!abort && in_valid) begin
            enc_q    <= enc_dec;
            key_q    <= key;
            l        <= data_in[BLOCK_W-1:HALF];
            r        <= data_in[HALF-1:0];
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            l   <= l_nxt;
            r   <= r_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              // final halves swapped so decrypt reuses the same datapath
              data_out  <= {r_nxt, l_nxt};
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feistel_cipher_core.sv
// Directed bench: a 16-bit single-round instance and a default 64-bit instance.
module tb_feistel_cipher_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 16-bit, 1-round instance
  logic        rst_a, in_valid_a, in_ready_a, enc_dec_a, out_valid_a, out_ready_a, busy_a, abort_a;
  logic [15:0] key_a, data_in_a, data_out_a;

  // default 64-bit, 16-round instance
  logic        rst_b, in_valid_b, in_ready_b, enc_dec_b, out_valid_b, out_ready_b, busy_b, abort_b;
  logic [63:0] key_b, data_in_b, data_out_b;

  feistel_cipher_core #(.BLOCK_W(16), .ROUNDS(1), .KEY_ROT(4)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .enc_dec(enc_dec_a), .key(key_a), .data_in(data_in_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .data_out(data_out_a), .busy(busy_a), .abort(abort_a)
  );

  feistel_cipher_core dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .enc_dec(enc_dec_b), .key(key_b), .data_in(data_in_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .data_out(data_out_b), .busy(busy_b), .abort(abort_b)
  );

  localparam logic [63:0] PT  = 64'hb26ac5634255852a;
  localparam logic [63:0] KEY = 64'h0f1571c9ac4198de;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for the 64-bit/16-round configuration; key rotated step by step
  function automatic logic [63:0] model64(input logic enc, input logic [63:0] k, input logic [63:0] d);
    logic [63:0] ks [16];
    logic [63:0] kr;
    logic [31:0] lh, rh, rk, t, fv, tmp;
    kr = k;
    for (int i = 0; i < 16; i++) begin
      ks[i] = kr;
      kr = {kr[59:0], kr[63:60]};
    end
    lh = d[63:32];
    rh = d[31:0];
    for (int i = 0; i < 16; i++) begin
      kr  = enc ? ks[i] : ks[15-i];
      rk  = kr[31:0];
      t   = rh ^ rk;
      fv  = {t[28:0], t[31:29]} + (rh & rk);
      tmp = lh ^ fv;
      lh  = rh;
      rh  = tmp;
    end
    return {rh, lh};
  endfunction

  // One transaction on the 16-bit instance; result due one cycle after accept
  task automatic xfer_a(input logic enc, input logic [15:0] k, input logic [15:0] d,
                        input logic [15:0] exp, input string tag);
    enc_dec_a = enc; key_a = k; data_in_a = d; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0; key_a = ~k; data_in_a = ~d; enc_dec_a = ~enc;
    check({tag, " busy"}, 64'(busy_a), 64'd1);
    check({tag, " in_ready low"}, 64'(in_ready_a), 64'd0);
    check({tag, " ov early"}, 64'(out_valid_a), 64'd0);
    tick();
    check({tag, " ov"}, 64'(out_valid_a), 64'd1);
    check({tag, " data"}, 64'(data_out_a), 64'(exp));
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    check({tag, " ov drop"}, 64'(out_valid_a), 64'd0);
    check({tag, " in_ready back"}, 64'(in_ready_a), 64'd1);
  endtask

  // One transaction on the 64-bit instance with optional back-pressure hold
  task automatic xfer_b(input logic enc, input logic [63:0] k, input logic [63:0] d,
                        input logic [63:0] exp, input int hold, input string tag);
    int lat;
    enc_dec_b = enc; key_b = k; data_in_b = d; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0; key_b = ~k; data_in_b = ~d; enc_dec_b = ~enc;
    lat = 0;
    while (!out_valid_b && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd16);
    check({tag, " data"}, data_out_b, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold data"}, data_out_b, exp);
      check({tag, " hold in_ready"}, 64'(in_ready_b), 64'd0);
      check({tag, " hold ov"}, 64'(out_valid_b), 64'd1);
    end
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    check({tag, " ov drop"}, 64'(out_valid_b), 64'd0);
    check({tag, " in_ready back"}, 64'(in_ready_b), 64'd1);
  endtask

  // No out_valid pulse may appear on the 64-bit instance for n cycles
  task automatic quiet_b(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | out_valid_b;
    end
    check({tag, " no ov pulse"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] ct;
    logic [63:0] ct2;
    rst_a = 1'b1; in_valid_a = 1'b0; enc_dec_a = 1'b0; key_a = '0; data_in_a = '0;
    out_ready_a = 1'b0; abort_a = 1'b0;
    rst_b = 1'b1; in_valid_b = 1'b0; enc_dec_b = 1'b0; key_b = '0; data_in_b = '0;
    out_ready_b = 1'b0; abort_b = 1'b0;
    repeat (10) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    check("rst a in_ready", 64'(in_ready_a), 64'd1);
    check("rst a ov", 64'(out_valid_a), 64'd0);
    check("rst a busy", 64'(busy_a), 64'd0);
    check("rst a data", 64'(data_out_a), 64'd0);
    check("rst b in_ready", 64'(in_ready_b), 64'd1);
    check("rst b ov", 64'(out_valid_b), 64'd0);
    check("rst b busy", 64'(busy_b), 64'd0);
    check("rst b data", data_out_b, 64'd0);

    // 16-bit vectors: F(34,FF)=5E+34=92, R'=12^92=80
    xfer_a(1'b1, 16'h00FF, 16'h1234, 16'h8034, "a enc");
    xfer_a(1'b0, 16'h00FF, 16'h8034, 16'h1234, "a dec");

    // abort in IDLE beats in_valid
    enc_dec_a = 1'b1; key_a = 16'h00FF; data_in_a = 16'h1234;
    in_valid_a = 1'b1; abort_a = 1'b1;
    tick();
    in_valid_a = 1'b0; abort_a = 1'b0;
    check("a idle abort in_ready", 64'(in_ready_a), 64'd1);
    check("a idle abort busy", 64'(busy_a), 64'd0);

    // abort during the single RUN cycle
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0; abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("a run abort ov", 64'(out_valid_a), 64'd0);
    check("a run abort in_ready", 64'(in_ready_a), 64'd1);
    check("a run abort data kept", 64'(data_out_a), 64'h1234);
    tick();
    check("a run abort no pulse", 64'(out_valid_a), 64'd0);
    xfer_a(1'b1, 16'h00FF, 16'h1234, 16'h8034, "a enc after abort");

    // 64-bit round trip with back-pressure on the encrypt result
    ct = model64(1'b1, KEY, PT);
    check("model round trip", model64(1'b0, KEY, ct), PT);
    xfer_b(1'b1, KEY, PT, ct, 20, "b enc");
    xfer_b(1'b0, KEY, ct, PT, 0, "b dec");

    // abort at round 5
    enc_dec_b = 1'b1; key_b = KEY; data_in_b = PT; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    repeat (5) tick();
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    check("b abort ov", 64'(out_valid_b), 64'd0);
    check("b abort in_ready", 64'(in_ready_b), 64'd1);
    check("b abort busy", 64'(busy_b), 64'd0);
    check("b abort data kept", data_out_b, PT);
    quiet_b(20, "b abort");

    // reset at round 8
    enc_dec_b = 1'b1; key_b = KEY; data_in_b = PT; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    repeat (8) tick();
    rst_b = 1'b1;
    #1;
    check("b midrst in_ready", 64'(in_ready_b), 64'd1);
    check("b midrst ov", 64'(out_valid_b), 64'd0);
    check("b midrst busy", 64'(busy_b), 64'd0);
    check("b midrst data", data_out_b, 64'd0);
    tick();
    rst_b = 1'b0;
    quiet_b(20, "b midrst");

    xfer_b(1'b1, KEY, PT, ct, 0, "b enc after rst");
    ct2 = model64(1'b0, 64'h0123456789abcdef, 64'hfedcba9876543210);
    xfer_b(1'b0, 64'h0123456789abcdef, 64'hfedcba9876543210, ct2, 2, "b dec vec2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/feistel_cipher_core.md
Name: feistel_cipher_core

Overview:
- Parametrised iterative Feistel block cipher core: encrypts or decrypts one BLOCK_W-bit block per transaction under a BLOCK_W-bit key, one round per clock.
- Successor to the fixed 64-bit, decrypt-only, start/done core.
- Adds runtime encrypt/decrypt mode, configurable width and round count, valid/ready handshakes on both sides, back-pressure and abort.
- Sits between the host register interface and the data buffers.

Parameters:
BLOCK_W, 64, block and key width in bits; must be even and >= 8; HALF = BLOCK_W/2.
ROUNDS, 16, number of Feistel rounds; must be >= 1.
KEY_ROT, 4, left-rotate step of the key schedule, in bits per round.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  core can accept a request.
enc_dec  input  1  1 = encrypt, 0 = decrypt; sampled on accept.
key  input  BLOCK_W  cipher key; sampled on accept.
data_in  input  BLOCK_W  plaintext or ciphertext; sampled on accept.
out_valid  output  1  data_out valid.
out_ready  input  1  downstream accepts data_out.
data_out  output  BLOCK_W  result.
busy  output  1  high in RUN or DONE.
abort  input  1  synchronous discard of the current operation.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, round counter=0, and internal L, R and key registers cleared.
- Key schedule: k_i = low HALF bits of rotl(key, (i*KEY_ROT) mod BLOCK_W), for i = 0..ROUNDS-1.
- Round function: F(X,k) = (rotl_HALF(X ^ k, 3) + (X & k)) mod 2^HALF.
- Round: L' = R; R' = L ^ F(R,k).
- Start of operation: L = data_in[BLOCK_W-1:HALF], R = data_in[HALF-1:0].
- Key order: encrypt uses k_0..k_{ROUNDS-1}; decrypt uses k_{ROUNDS-1}..k_0.
- Result: data_out = {R_final, L_final} (final halves swapped). This makes decrypt(encrypt(x)) == x with the same datapath.
- FSM IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch enc_dec, key and data_in into L/R; counter=0; go to RUN.
- FSM RUN:
  - in_ready=0.
  - Each edge performs one round and increments the counter.
  - After the round with counter=ROUNDS-1, load data_out and set out_valid=1; go to DONE.
- FSM DONE:
  - out_valid and data_out hold stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0; go to IDLE.
  - in_ready is not combinationally tied to out_ready, so there is no back-to-back accept in the same cycle.
- Latency: accept at edge E; out_valid rises at edge E+ROUNDS. Throughput: one block per ROUNDS+2 cycles minimum.
- Ports are sampled only on accept. Changes to key, data_in or enc_dec during RUN/DONE have no effect.
- abort:
  - At any edge in RUN or DONE: return to IDLE, out_valid=0, data_out unchanged, no result produced.
  - In IDLE, abort has priority over in_valid: nothing is accepted.
- Simultaneous abort and out_ready in DONE: abort wins. The outcome is identical (IDLE, out_valid=0).
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the in-flight block is lost.
- All arithmetic is mod 2^HALF. Rotates wrap within HALF bits (F) or BLOCK_W bits (key).

Test Plan:
- Reset: rst=1 for 10 cycles, then release -> in_ready=1, out_valid=0, busy=0, data_out=0.
- BLOCK_W=16, ROUNDS=1, encrypt, key=16'h00FF, data_in=16'h1234 -> data_out=16'h8034, out_valid exactly 1 cycle after accept.
- BLOCK_W=16, ROUNDS=1, decrypt, key=16'h00FF, data_in=16'h8034 -> data_out=16'h1234.
- Default parameters:
  - Encrypt 64'hb26ac5634255852a under key 64'h0f1571c9ac4198de, then decrypt the result under the same key -> 64'hb26ac5634255852a.
  - out_valid rises 16 cycles after each accept.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> data_out stable, in_ready=0 throughout; one cycle with out_ready=1 -> out_valid=0, in_ready=1 on the next cycle.
- abort at round 5, and a separate case with rst asserted at round 8 -> no out_valid pulse, in_ready=1 next cycle. A following encrypt of 16'h1234 (16-bit configuration) still yields 16'h8034.
